timer_device: RTL and testbench

Memory-mapped countdown timer that acts as the responder on the processor bridge bus. The CPU drives address, write data and write enable from its memory stage and samples read data combinationally in the same cycle. The timer decodes three word registers and counts down a preset value. It raises an interrupt line that the bridge routes into one bit of the CPU's `HWInt[7:2]` vector.

---
 rtl/timer_device.sv | 138 +++++++++++++
 tb/tb_timer_device.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_device.sv
// timer_device: memory-mapped countdown timer (CTRL/PRESET/COUNT) that drives an interrupt line.
// Define TIMER_PRESCALE_EN to make CTRL[15:8] a writable count prescaler.
module timer_device #(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT,
    output logic        IRQ
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] CNT  = 2'd2;
    localparam logic [1:0] INT  = 2'd3;

    localparam logic [1:0] MODE_AUTO = 2'b01;

    logic [1:0]       state;
    logic             enable;
    logic [1:0]       mode;
    logic             im;
    logic             pending;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic [7:0]       prescale;
    logic             tick;
    logic             ctrlWr;
    logic             presetWr;

    assign ctrlWr   = WE && (Addr == ADDR_CTRL);
    assign presetWr = WE && (Addr == ADDR_PRESET);

`ifdef TIMER_PRESCALE_EN
    logic [7:0] psCnt;

    // Prescale counter only advances while counting; LOAD and CTRL writes restart it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prescale <= '0;
            psCnt    <= '0;
        end else begin
            if (ctrlWr) begin
                prescale <= DIN[15:8];
            end
            if (ctrlWr || (state != CNT) || tick) begin
                psCnt <= '0;
            end else begin
                psCnt <= psCnt + 8'd1;
            end
        end
    end

    assign tick = (psCnt == prescale);
`else
    assign prescale = '0;
    assign tick     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            enable  <= 1'b0;
            mode    <= '0;
            im      <= 1'b0;
            pending <= 1'b0;
            preset  <= '0;
            count   <= '0;
        end else begin
            // A CTRL write overrides whatever the state machine would do this edge.
            if (ctrlWr) begin
                enable  <= DIN[0];
                mode    <= DIN[2:1];
                im      <= DIN[3];
                pending <= 1'b0;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable) begin
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        count   <= preset;
                        pending <= 1'b0;
                        state   <= CNT;
                    end
                    CNT: begin
                        if (tick) begin
                            if (!enable) begin
                                state <= IDLE;
                            end else if (count <= CNT_W'(1)) begin
                                count <= '0;
                                state <= INT;
                            end else begin
                                count <= count - CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        pending <= 1'b1;
                        if (mode == MODE_AUTO) begin
                            state <= LOAD;
                        end else begin
                            enable <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                endcase
            end

            if (presetWr) begin
                preset <= DIN[CNT_W-1:0];
            end
        end
    end

    always_comb begin
        DOUT = '0;
        case (Addr)
            ADDR_CTRL:   DOUT = {16'h0000, prescale, 4'h0, im, mode, enable};
            ADDR_PRESET: DOUT[CNT_W-1:0] = preset;
            ADDR_COUNT:  DOUT[CNT_W-1:0] = count;
            default:     DOUT = '0;
        endcase
    end

    assign IRQ = im & pending;

endmodule

// File: tb/tb_timer_device.sv
// Self-checking bench for timer_device: constant vector table, directed corner sequences,
// and randomized bus traffic compared against a closed-form timing model.
module tb_timer_device;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        WE    = 1'b0;
    logic [1:0]  Addr  = 2'd0;
    logic [31:0] DIN   = 32'h0;
    logic [31:0] DOUT;
    logic        IRQ;

    timer_device #(.CNT_W(32)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .DIN  (DIN),
        .DOUT (DOUT),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit modelOn = 1'b0;

    // Reference model: a load at edge L with value N yields COUNT = max(N-(t-L),0),
    // pending at L+max(N,1)+1, and (auto-reload) the next load one edge later.
    longint      t      = 0;
    longint      loadAt = -1;
    longint      L      = 0;
    longint      N      = 0;
    longint      pendAt = 0;
    bit          running = 1'b0;
    logic        mEn   = 1'b0;
    logic        mIm   = 1'b0;
    logic        mPend = 1'b0;
    logic [1:0]  mMode = 2'd0;
    logic [7:0]  mPsc  = 8'd0;
    logic [31:0] mPre  = 32'd0;
    logic [31:0] mCount = 32'd0;

    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [31:0] expD;
        logic        expI;
    } vec_t;

    vec_t vecs[20];

    logic [31:0] dd;
    logic        ii;
    int          pulses;
    int          lastP;
    bit          after;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [1:0] a);
        case (a)
            2'd0:    return {16'h0000, mPsc, 4'h0, mIm, mMode, mEn};
            2'd1:    return mPre;
            2'd2:    return mCount;
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelStep(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
        if (!r) begin
            mEn = 0; mIm = 0; mPend = 0; mMode = 0; mPsc = 0; mPre = 0; mCount = 0;
            running = 0; loadAt = -1;
        end else if (w && a == 2'd0) begin
            mEn = d[0]; mMode = d[2:1]; mIm = d[3];
`ifdef TIMER_PRESCALE_EN
            mPsc = d[15:8];
`endif
            mPend = 0;
            running = 0;
            loadAt = d[0] ? t + 2 : -1;
        end else begin
            if (t == loadAt) begin
                running = 1; L = t; N = longint'(mPre);
                pendAt = L + ((N == 0) ? 1 : N) + 1;
                loadAt = -1; mPend = 0;
            end
            if (running) mCount = ((t - L) >= N) ? 32'd0 : 32'(N - (t - L));
            if (running && t == pendAt) begin
                mPend = 1; running = 0;
                if (mMode == 2'b01) loadAt = t + 1;
                else mEn = 0;
            end
            if (w && a == 2'd1) mPre = d;
        end
        t++;
    endtask

    task automatic doCycle(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d,
                           output logic [31:0] dOut, output logic irqOut);
        @(negedge clk);
        reset = r; WE = w; Addr = a; DIN = d;
        #1;
        dOut = DOUT;
        irqOut = IRQ;
        if (modelOn) begin
            check("model_dout", DOUT, modelRead(a));
            check("model_irq", {31'h0, IRQ}, {31'h0, mIm & mPend});
        end
        @(posedge clk);
        modelStep(r, w, a, d);
    endtask

    task automatic cyc(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] x;
        logic        y;
        doCycle(r, w, a, d, x, y);
    endtask

    task automatic op(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d,
                      input logic [31:0] expD, input logic expI, input string name);
        logic [31:0] x;
        logic        y;
        doCycle(r, w, a, d, x, y);
        check({name, "_dout"}, x, expD);
        check({name, "_irq"}, {31'h0, y}, {31'h0, expI});
    endtask

    task automatic resetDut();
        cyc(1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    initial begin
        // Reset with random bus traffic, then every register reads zero.
        cyc(1'b0, 1'b1, 2'($urandom_range(0, 3)), $urandom);
        modelOn = 1'b1;
        cyc(1'b0, 1'b1, 2'($urandom_range(0, 3)), $urandom);
        op(1, 0, 2'd0, 0, 32'h0, 0, "rst_ctrl");
        op(1, 0, 2'd1, 0, 32'h0, 0, "rst_preset");
        op(1, 0, 2'd2, 0, 32'h0, 0, "rst_count");

        // One-shot PRESET=5, CTRL=0x9, then clear, COUNT/reserved writes.
        vecs[0]  = '{1'b1, 1'b1, 2'd1, 32'd5,    32'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 2'd0, 32'h9,    32'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'd2, 32'd0,    32'd0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'd2, 32'd0,    32'd0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 2'd2, 32'd0,    32'd5, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2'd2, 32'd0,    32'd4, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 2'd2, 32'd0,    32'd3, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 2'd2, 32'd0,    32'd2, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'd2, 32'd0,    32'd1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 2'd2, 32'd0,    32'd0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 2'd2, 32'd0,    32'd0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 32'd0,    32'h8, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 2'd1, 32'd0,    32'd5, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 2'd0, 32'h8,    32'h8, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 2'd0, 32'd0,    32'h8, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 2'd2, 32'h55,   32'd0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 2'd2, 32'd0,    32'd0, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 2'd3, 32'hff,   32'd0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 2'd3, 32'd0,    32'd0, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 2'd1, 32'd0,    32'd5, 1'b0};
        resetDut();
        for (int i = 0; i < 20; i++) begin
            op(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].expD, vecs[i].expI,
               $sformatf("vec%0d", i));
        end

        // Auto-reload PRESET=3: one-cycle pulses every 5 cycles, COUNT back at 3 after each.
        resetDut();
        cyc(1, 1, 2'd1, 32'd3);
        cyc(1, 1, 2'd0, 32'hB);
        pulses = 0; lastP = -1; after = 0;
        for (int i = 0; i < 30; i++) begin
            doCycle(1, 0, 2'd2, 32'd0, dd, ii);
            if (after) begin
                check("auto_reload_count", dd, 32'd3);
                check("auto_pulse_width", {31'h0, ii}, 32'd0);
            end
            after = ii;
            if (ii) begin
                if (lastP < 0) check("auto_first_pulse", 32'(i), 32'd6);
                else check("auto_period", 32'(i - lastP), 32'd5);
                lastP = i;
                pulses++;
            end
        end
        check("auto_pulses", 32'(pulses), 32'd5);
        cyc(1, 1, 2'd0, 32'h0);

        // PRESET=0 masked: INT after 3 edges, Enable drops, IRQ stays low.
        resetDut();
        cyc(1, 1, 2'd1, 32'd0);
        cyc(1, 1, 2'd0, 32'h1);
        op(1, 0, 2'd0, 0, 32'h1, 0, "mask_e0");
        op(1, 0, 2'd0, 0, 32'h1, 0, "mask_e1");
        op(1, 0, 2'd0, 0, 32'h1, 0, "mask_e2");
        op(1, 0, 2'd0, 0, 32'h1, 0, "mask_e3");
        op(1, 0, 2'd0, 0, 32'h0, 0, "mask_e4");
        // Unmasked PRESET=0: IRQ 4 edges after the write.
        op(1, 1, 2'd0, 32'h9, 32'h0, 0, "zero_wr");
        op(1, 0, 2'd2, 0, 32'h0, 0, "zero_e0");
        op(1, 0, 2'd2, 0, 32'h0, 0, "zero_e1");
        op(1, 0, 2'd2, 0, 32'h0, 0, "zero_e2");
        op(1, 0, 2'd2, 0, 32'h0, 0, "zero_e3");
        op(1, 0, 2'd0, 0, 32'h8, 1, "zero_e4");

        // CTRL write in the INT cycle wins: pending stays 0, Enable kept, count restarts.
        resetDut();
        cyc(1, 1, 2'd1, 32'd2);
        cyc(1, 1, 2'd0, 32'h9);
        for (int i = 0; i < 4; i++) cyc(1, 0, 2'd2, 32'd0);
        op(1, 1, 2'd0, 32'h9, 32'h9, 0, "col_int_wr");
        op(1, 0, 2'd0, 0, 32'h9, 0, "col_ctrl");
        op(1, 0, 2'd2, 0, 32'h0, 0, "col_e1");
        op(1, 0, 2'd2, 0, 32'h2, 0, "col_e2");
        op(1, 0, 2'd2, 0, 32'h1, 0, "col_e3");
        op(1, 0, 2'd2, 0, 32'h0, 0, "col_e4");
        op(1, 0, 2'd2, 0, 32'h0, 1, "col_e5");

        // PRESET write mid-count only takes effect at the next reload.
        resetDut();
        cyc(1, 1, 2'd1, 32'd4);
        cyc(1, 1, 2'd0, 32'h3);
        cyc(1, 0, 2'd2, 32'd0);
        cyc(1, 0, 2'd2, 32'd0);
        op(1, 0, 2'd2, 0, 32'd4, 0, "pre_e2");
        op(1, 1, 2'd1, 32'd9, 32'd4, 0, "pre_wr");
        op(1, 0, 2'd2, 0, 32'd2, 0, "pre_e4");
        op(1, 0, 2'd2, 0, 32'd1, 0, "pre_e5");
        op(1, 0, 2'd2, 0, 32'd0, 0, "pre_e6");
        op(1, 0, 2'd2, 0, 32'd0, 0, "pre_e7");
        op(1, 0, 2'd2, 0, 32'd9, 0, "pre_reload");

        // Reset while IRQ is high clears everything on that edge.
        resetDut();
        cyc(1, 1, 2'd1, 32'd1);
        cyc(1, 1, 2'd0, 32'h9);
        for (int i = 0; i < 4; i++) cyc(1, 0, 2'd2, 32'd0);
        op(0, 1, 2'd2, 32'h77, 32'd0, 1, "rstmid_pre");
        op(1, 0, 2'd0, 0, 32'd0, 0, "rstmid_ctrl");
        op(1, 0, 2'd1, 0, 32'd0, 0, "rstmid_preset");
        op(1, 0, 2'd2, 0, 32'd0, 0, "rstmid_count");

`ifdef TIMER_PRESCALE_EN
        // P=3: every COUNT value holds for 4 cycles.
        resetDut();
        cyc(1, 1, 2'd1, 32'd2);
        modelOn = 1'b0;
        op(1, 1, 2'd0, 32'h0309, 32'h0, 0, "psc_wr");
        op(1, 0, 2'd0, 0, 32'h0309, 0, "psc_ctrl");
        op(1, 0, 2'd2, 0, 32'd0, 0, "psc_load");
        for (int i = 0; i < 4; i++) op(1, 0, 2'd2, 0, 32'd2, 0, "psc_two");
        for (int i = 0; i < 4; i++) op(1, 0, 2'd2, 0, 32'd1, 0, "psc_one");
        op(1, 0, 2'd2, 0, 32'd0, 0, "psc_zero");
        resetDut();
        modelOn = 1'b1;
`else
        resetDut();
        op(1, 1, 2'd0, 32'h0309, 32'h0, 0, "psc_off_wr");
        op(1, 0, 2'd0, 0, 32'h0009, 0, "psc_off_ctrl");
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        w;
            logic [1:0]  a;
            logic [31:0] d;
            r = ($urandom_range(0, 299) != 0);
            a = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 3) == 0);
            if (w && a == 2'd0 && $urandom_range(0, 3) != 0) w = 1'b0;
            d = (a == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
`ifdef TIMER_PRESCALE_EN
            if (a == 2'd0) d[15:8] = 8'h00;
`endif
            doCycle(r, w, a, d, dd, ii);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
